// File: rtl/stream_scoreboard.sv
// Multi-channel in-order scoreboard: expected words queue per channel and are
// compared against DUT words, with saturating counters and an end-of-test verdict.
module stream_scoreboard #(
    parameter int N_CHANNELS    = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int CNT_WIDTH     = 16,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                             pi_clk,
    input  logic                             pi_rst,
    input  logic                             pi_start,
    input  logic                             pi_end_of_test,
    input  logic [DATA_WIDTH-1:0]            pi_cmp_mask,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] pi_exp_data,
    input  logic [N_CHANNELS-1:0]            pi_exp_valid,
    output logic [N_CHANNELS-1:0]            po_exp_ready,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] pi_act_data,
    input  logic [N_CHANNELS-1:0]            pi_act_valid,
    output logic [N_CHANNELS*CNT_WIDTH-1:0]  po_match_cnt,
    output logic [N_CHANNELS*CNT_WIDTH-1:0]  po_mismatch_cnt,
    output logic [N_CHANNELS-1:0]            po_underflow,
    output logic [N_CHANNELS-1:0]            po_leftover,
    output logic                             po_first_err_valid,
    output logic [2:0]                       po_first_err_chan,
    output logic [DATA_WIDTH-1:0]            po_first_err_exp,
    output logic [DATA_WIDTH-1:0]            po_first_err_act,
    output logic                             po_busy,
    output logic                             po_done,
    output logic                             po_pass
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [AW:0]           OCC_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0]           OCC_ZERO   = {(AW+1){1'b0}};
    localparam logic [TW-1:0]         DRAIN_LAST = TW'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CHECK = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

    state_t                r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_mem      [N_CHANNELS][DEPTH];
    logic [AW-1:0]         r_wr_ptr   [N_CHANNELS];
    logic [AW-1:0]         r_rd_ptr   [N_CHANNELS];
    logic [AW:0]           r_occ      [N_CHANNELS];
    logic [CNT_WIDTH-1:0]  r_match    [N_CHANNELS];
    logic [CNT_WIDTH-1:0]  r_mismatch [N_CHANNELS];
    logic [N_CHANNELS-1:0] r_underflow, r_leftover;
    logic [DATA_WIDTH-1:0] r_mask, r_fe_exp, r_fe_act;
    logic                  r_fe_valid, r_busy, r_done, r_pass;
    logic [2:0]            r_fe_chan;
    logic [TW-1:0]         r_drain_cnt;

    logic [DATA_WIDTH-1:0] w_head [N_CHANNELS];
    logic [DATA_WIDTH-1:0] w_act  [N_CHANNELS];
    logic [N_CHANNELS-1:0] w_full, w_empty, w_push, w_pop, w_miss, w_uflow, w_left_next;
    logic                  w_active, w_clear, w_drain_exit, w_pass_next, w_err_any;
    logic [2:0]            w_err_chan;
    logic [DATA_WIDTH-1:0] w_err_exp, w_err_act;

    // Per-channel handshake, compare decode, verdict inputs and first-error priority.
    always_comb begin
        w_active    = (r_state == S_CHECK) || (r_state == S_DRAIN);
        w_clear     = pi_start && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_pass_next = 1'b1;
        w_err_any   = 1'b0;
        w_err_chan  = 3'd0;
        w_err_exp   = DATA_ZERO;
        w_err_act   = DATA_ZERO;
        for (int c = 0; c < N_CHANNELS; c++) begin
            w_act[c]       = pi_act_data[c*DATA_WIDTH +: DATA_WIDTH];
            w_head[c]      = r_mem[c][r_rd_ptr[c]];
            w_full[c]      = (r_occ[c] == OCC_FULL);
            w_empty[c]     = (r_occ[c] == OCC_ZERO);
            w_push[c]      = (r_state == S_CHECK) && pi_exp_valid[c] && !w_full[c];
            w_pop[c]       = w_active && pi_act_valid[c] && !w_empty[c];
            w_miss[c]      = w_pop[c] && (((w_act[c] ^ w_head[c]) & r_mask) != DATA_ZERO);
            w_uflow[c]     = w_active && pi_act_valid[c] && w_empty[c];
            w_left_next[c] = (r_occ[c] > {{AW{1'b0}}, w_pop[c]});
            w_pass_next    = w_pass_next & (r_mismatch[c] == {CNT_WIDTH{1'b0}}) & ~w_miss[c]
                           & ~r_underflow[c] & ~w_uflow[c] & ~w_left_next[c];
        end
        // Scan downwards so the lowest failing channel is the one left standing.
        for (int c = N_CHANNELS - 1; c >= 0; c--) begin
            if (w_miss[c] || w_uflow[c]) begin
                w_err_any  = 1'b1;
                w_err_chan = 3'(c);
                w_err_exp  = w_miss[c] ? w_head[c] : DATA_ZERO;
                w_err_act  = w_act[c];
            end else begin
                w_err_any  = w_err_any;
            end
        end
        w_drain_exit = (&w_empty) || (r_drain_cnt == DRAIN_LAST);
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = pi_start       ? S_CHECK : S_IDLE;
            S_CHECK: w_state_next = pi_end_of_test ? S_DRAIN : S_CHECK;
            S_DRAIN: w_state_next = w_drain_exit   ? S_DONE  : S_DRAIN;
            S_DONE:  w_state_next = pi_start       ? S_CHECK : S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register with registered busy/done decode.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == S_CHECK) || (w_state_next == S_DRAIN);
            r_done  <= (w_state_next == S_DONE);
        end
    end

    // Expected-word storage; no reset needed since occupancy gates every read.
    always_ff @(posedge pi_clk) begin
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (w_push[c]) r_mem[c][r_wr_ptr[c]] <= pi_exp_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // FIFO pointers, counters, sticky flags, first-error capture and verdict.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_wr_ptr[c]   <= {AW{1'b0}};
                r_rd_ptr[c]   <= {AW{1'b0}};
                r_occ[c]      <= OCC_ZERO;
                r_match[c]    <= {CNT_WIDTH{1'b0}};
                r_mismatch[c] <= {CNT_WIDTH{1'b0}};
            end
            r_underflow <= {N_CHANNELS{1'b0}};
            r_leftover  <= {N_CHANNELS{1'b0}};
            r_mask      <= DATA_ZERO;
            r_fe_valid  <= 1'b0;
            r_fe_chan   <= 3'd0;
            r_fe_exp    <= DATA_ZERO;
            r_fe_act    <= DATA_ZERO;
            r_pass      <= 1'b0;
            r_drain_cnt <= {TW{1'b0}};
        end else if (w_clear) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_wr_ptr[c]   <= {AW{1'b0}};
                r_rd_ptr[c]   <= {AW{1'b0}};
                r_occ[c]      <= OCC_ZERO;
                r_match[c]    <= {CNT_WIDTH{1'b0}};
                r_mismatch[c] <= {CNT_WIDTH{1'b0}};
            end
            r_underflow <= {N_CHANNELS{1'b0}};
            r_leftover  <= {N_CHANNELS{1'b0}};
            r_mask      <= pi_cmp_mask;
            r_fe_valid  <= 1'b0;
            r_fe_chan   <= 3'd0;
            r_fe_exp    <= DATA_ZERO;
            r_fe_act    <= DATA_ZERO;
            r_pass      <= 1'b0;
            r_drain_cnt <= {TW{1'b0}};
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (w_push[c]) r_wr_ptr[c] <= r_wr_ptr[c] + AW'(1);
                if (w_pop[c])  r_rd_ptr[c] <= r_rd_ptr[c] + AW'(1);
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_occ[c] <= r_occ[c] + (AW+1)'(1);
                    2'b01:   r_occ[c] <= r_occ[c] - (AW+1)'(1);
                    default: r_occ[c] <= r_occ[c];
                endcase
                if (w_pop[c] && !w_miss[c] && (r_match[c] != CNT_MAX))
                    r_match[c] <= r_match[c] + CNT_WIDTH'(1);
                if (w_miss[c] && (r_mismatch[c] != CNT_MAX))
                    r_mismatch[c] <= r_mismatch[c] + CNT_WIDTH'(1);
            end
            r_underflow <= r_underflow | w_uflow;
            if (!r_fe_valid && w_err_any) begin
                r_fe_valid <= 1'b1;
                r_fe_chan  <= w_err_chan;
                r_fe_exp   <= w_err_exp;
                r_fe_act   <= w_err_act;
            end
            if ((r_state == S_DRAIN) && w_drain_exit) begin
                r_leftover <= w_left_next;
                r_pass     <= w_pass_next;
            end
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + TW'(1) : {TW{1'b0}};
        end
    end

    // Output packing.
    always_comb begin
        po_match_cnt    = {(N_CHANNELS*CNT_WIDTH){1'b0}};
        po_mismatch_cnt = {(N_CHANNELS*CNT_WIDTH){1'b0}};
        for (int c = 0; c < N_CHANNELS; c++) begin
            po_match_cnt[c*CNT_WIDTH +: CNT_WIDTH]    = r_match[c];
            po_mismatch_cnt[c*CNT_WIDTH +: CNT_WIDTH] = r_mismatch[c];
            po_exp_ready[c] = (r_state == S_CHECK) && !w_full[c];
        end
    end

    assign po_underflow       = r_underflow;
    assign po_leftover        = r_leftover;
    assign po_first_err_valid = r_fe_valid;
    assign po_first_err_chan  = r_fe_chan;
    assign po_first_err_exp   = r_fe_exp;
    assign po_first_err_act   = r_fe_act;
    assign po_busy            = r_busy;
    assign po_done            = r_done;
    assign po_pass            = r_pass;

endmodule

// File: tb/tb_stream_scoreboard.sv
// Scoreboard bench: stimulus queues expected output values; a monitor compares
// them when the DUT raises po_done or when the stimulus requests a snapshot.
module tb_stream_scoreboard;

    localparam int SEL_MATCH0 = 0, SEL_MATCH1 = 1, SEL_MIS0 = 2, SEL_MIS1 = 3;
    localparam int SEL_UF = 4, SEL_LEFT = 5, SEL_FEV = 6, SEL_FEC = 7, SEL_FEE = 8;
    localparam int SEL_FEA = 9, SEL_BUSY = 10, SEL_DONE = 11, SEL_PASS = 12;
    localparam int SEL_READY = 13, SEL_ZERO = 14, SEL_DRAIN = 15;

    logic        clk = 1'b0;
    logic        pi_rst, pi_start, pi_end_of_test;
    logic [7:0]  pi_cmp_mask;
    logic [15:0] pi_exp_data, pi_act_data;
    logic [1:0]  pi_exp_valid, pi_act_valid, po_exp_ready, po_underflow, po_leftover;
    logic [31:0] po_match_cnt, po_mismatch_cnt;
    logic        po_first_err_valid, po_busy, po_done, po_pass;
    logic [2:0]  po_first_err_chan;
    logic [7:0]  po_first_err_exp, po_first_err_act;

    always #5 clk = ~clk;

    stream_scoreboard #(.N_CHANNELS(2), .DATA_WIDTH(8), .DEPTH(16), .CNT_WIDTH(16),
                        .DRAIN_TIMEOUT(8)) dut (
        .pi_clk(clk), .pi_rst(pi_rst), .pi_start(pi_start), .pi_end_of_test(pi_end_of_test),
        .pi_cmp_mask(pi_cmp_mask), .pi_exp_data(pi_exp_data), .pi_exp_valid(pi_exp_valid),
        .po_exp_ready(po_exp_ready), .pi_act_data(pi_act_data), .pi_act_valid(pi_act_valid),
        .po_match_cnt(po_match_cnt), .po_mismatch_cnt(po_mismatch_cnt),
        .po_underflow(po_underflow), .po_leftover(po_leftover),
        .po_first_err_valid(po_first_err_valid), .po_first_err_chan(po_first_err_chan),
        .po_first_err_exp(po_first_err_exp), .po_first_err_act(po_first_err_act),
        .po_busy(po_busy), .po_done(po_done), .po_pass(po_pass)
    );

    typedef struct {
        int          sel;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [63:0] mon_got;
    int          total = 0, passed = 0, drain_len = 0;
    logic        snap = 1'b0, done_q = 1'b0;

    function automatic logic [63:0] get_val(input int sel);
        case (sel)
            SEL_MATCH0: return 64'(po_match_cnt[15:0]);
            SEL_MATCH1: return 64'(po_match_cnt[31:16]);
            SEL_MIS0:   return 64'(po_mismatch_cnt[15:0]);
            SEL_MIS1:   return 64'(po_mismatch_cnt[31:16]);
            SEL_UF:     return 64'(po_underflow);
            SEL_LEFT:   return 64'(po_leftover);
            SEL_FEV:    return 64'(po_first_err_valid);
            SEL_FEC:    return 64'(po_first_err_chan);
            SEL_FEE:    return 64'(po_first_err_exp);
            SEL_FEA:    return 64'(po_first_err_act);
            SEL_BUSY:   return 64'(po_busy);
            SEL_DONE:   return 64'(po_done);
            SEL_PASS:   return 64'(po_pass);
            SEL_READY:  return 64'(po_exp_ready);
            SEL_ZERO:   return 64'(|{po_exp_ready, po_match_cnt, po_mismatch_cnt, po_underflow,
                                     po_leftover, po_first_err_valid, po_first_err_chan,
                                     po_first_err_exp, po_first_err_act, po_busy, po_done, po_pass});
            SEL_DRAIN:  return 64'(drain_len);
            default:    return 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
    endfunction

    // Monitor: drain and compare all queued expectations on a verdict or snapshot.
    always @(negedge clk) begin
        if (snap || (po_done === 1'b1 && done_q !== 1'b1)) begin
            while (sbq.size() > 0) begin
                mon_e   = sbq.pop_front();
                mon_got = get_val(mon_e.sel);
                total++;
                if (mon_got === mon_e.val) passed++;
                else $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_e.name, mon_got, mon_e.val);
            end
        end
        done_q = po_done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int sel, input logic [63:0] v, input string n);
        exp_t e;
        e.sel = sel; e.val = v; e.name = n;
        sbq.push_back(e);
    endtask

    task automatic snap_now();
        snap = 1'b1;
        @(negedge clk);
        #1;
        snap = 1'b0;
        step();
    endtask

    task automatic start_test(input logic [7:0] m);
        pi_cmp_mask = m;
        pi_start    = 1'b1;
        step();
        pi_start    = 1'b0;
    endtask

    task automatic push_exp(input int ch, input logic [7:0] d);
        pi_exp_data[ch*8 +: 8] = d;
        pi_exp_valid[ch]       = 1'b1;
        step();
        pi_exp_valid           = 2'b00;
    endtask

    task automatic drive_act(input int ch, input logic [7:0] d);
        pi_act_data[ch*8 +: 8] = d;
        pi_act_valid[ch]       = 1'b1;
        step();
        pi_act_valid           = 2'b00;
    endtask

    task automatic end_test();
        int n;
        pi_end_of_test = 1'b1;
        step();
        pi_end_of_test = 1'b0;
        n = 0;
        while (po_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        drain_len = n;
        if (n >= 200) begin
            $display("FAIL done_timeout: po_done still 0 after %0d cycles, required 1", n);
            total = total + 1 + sbq.size();
            sbq.delete();
        end
        step();
    endtask

    initial begin
        pi_rst = 1'b1; pi_start = 1'b0; pi_end_of_test = 1'b0; pi_cmp_mask = 8'h00;
        pi_exp_data = 16'h0000; pi_act_data = 16'h0000;
        pi_exp_valid = 2'b00; pi_act_valid = 2'b00;
        chk(SEL_ZERO, 64'd0, "reset_outputs");
        snap_now();
        pi_rst = 1'b0;
        step();

        // Full match on both channels.
        start_test(8'hFF);
        chk(SEL_BUSY, 64'd1, "busy_after_start"); chk(SEL_DONE, 64'd0, "done_after_start");
        snap_now();
        for (int i = 0; i < 16; i++) begin
            pi_exp_data = {8'hF0 + 8'(i), 8'(i)}; pi_exp_valid = 2'b11; step();
        end
        pi_exp_valid = 2'b00;
        for (int i = 0; i < 16; i++) begin
            pi_act_data = {8'hF0 + 8'(i), 8'(i)}; pi_act_valid = 2'b11; step();
        end
        pi_act_valid = 2'b00;
        chk(SEL_MATCH0, 64'd16, "full_match0"); chk(SEL_MATCH1, 64'd16, "full_match1");
        chk(SEL_MIS0, 64'd0, "full_mis0"); chk(SEL_MIS1, 64'd0, "full_mis1");
        chk(SEL_PASS, 64'd1, "full_pass"); chk(SEL_DRAIN, 64'd1, "empty_drain_len");
        end_test();

        // Masked compare: only the upper nibble matters.
        start_test(8'hF0);
        push_exp(0, 8'h35); drive_act(0, 8'h3A);
        chk(SEL_MATCH0, 64'd1, "mask_match0"); chk(SEL_MIS0, 64'd0, "mask_mis0");
        chk(SEL_PASS, 64'd1, "mask_pass"); chk(SEL_FEV, 64'd0, "mask_fe_valid");
        end_test();

        start_test(8'hFF);
        push_exp(0, 8'h35); drive_act(0, 8'h3A);
        chk(SEL_MATCH0, 64'd0, "nomask_match0"); chk(SEL_MIS0, 64'd1, "nomask_mis0");
        chk(SEL_FEV, 64'd1, "nomask_fe_valid"); chk(SEL_FEC, 64'd0, "nomask_fe_chan");
        chk(SEL_FEE, 64'h35, "nomask_fe_exp"); chk(SEL_FEA, 64'h3A, "nomask_fe_act");
        chk(SEL_PASS, 64'd0, "nomask_pass");
        end_test();

        // Underflow on ch1 in the same cycle as a ch0 mismatch.
        start_test(8'hFF);
        push_exp(0, 8'h11);
        pi_act_data = {8'h55, 8'h22}; pi_act_valid = 2'b11; step(); pi_act_valid = 2'b00;
        chk(SEL_UF, 64'h2, "prio_underflow"); chk(SEL_FEC, 64'd0, "prio_fe_chan");
        chk(SEL_FEE, 64'h11, "prio_fe_exp"); chk(SEL_FEA, 64'h22, "prio_fe_act");
        chk(SEL_MIS0, 64'd1, "prio_mis0"); chk(SEL_MATCH1, 64'd0, "prio_match1");
        chk(SEL_PASS, 64'd0, "prio_pass");
        end_test();

        // Backpressure: fill ch0, refused push, pop, push+pop, refill.
        start_test(8'hFF);
        for (int i = 0; i < 16; i++) push_exp(0, 8'h40 + 8'(i));
        chk(SEL_READY, 64'h2, "ready_full"); snap_now();
        push_exp(0, 8'h99);
        drive_act(0, 8'h40);
        chk(SEL_READY, 64'h3, "ready_after_pop"); snap_now();
        pi_exp_data[7:0] = 8'h50; pi_exp_valid = 2'b01;
        pi_act_data[7:0] = 8'h41; pi_act_valid = 2'b01;
        step(); pi_exp_valid = 2'b00; pi_act_valid = 2'b00;
        chk(SEL_READY, 64'h3, "ready_push_pop"); snap_now();
        push_exp(0, 8'h51);
        chk(SEL_READY, 64'h2, "ready_refull"); snap_now();
        for (int i = 0; i < 16; i++) drive_act(0, 8'h42 + 8'(i));
        chk(SEL_MATCH0, 64'd18, "bp_match0"); chk(SEL_MIS0, 64'd0, "bp_mis0");
        chk(SEL_LEFT, 64'd0, "bp_leftover"); chk(SEL_PASS, 64'd1, "bp_pass");
        end_test();

        // Leftover words force the drain timeout.
        start_test(8'hFF);
        push_exp(0, 8'h01); push_exp(0, 8'h02); push_exp(0, 8'h03);
        drive_act(0, 8'h01);
        chk(SEL_DRAIN, 64'd8, "timeout_drain_len"); chk(SEL_LEFT, 64'h1, "timeout_leftover");
        chk(SEL_PASS, 64'd0, "timeout_pass"); chk(SEL_MATCH0, 64'd1, "timeout_match0");
        end_test();

        // Restart from DONE clears everything.
        start_test(8'hFF);
        chk(SEL_LEFT, 64'd0, "restart_leftover"); chk(SEL_MATCH0, 64'd0, "restart_match0");
        chk(SEL_DONE, 64'd0, "restart_done"); chk(SEL_BUSY, 64'd1, "restart_busy");
        snap_now();

        // Saturation: stream many matching words through a single-entry occupancy.
        pi_exp_data[7:0] = 8'h00; pi_act_data[7:0] = 8'h00;
        pi_exp_valid = 2'b01; step();
        pi_act_valid = 2'b01;
        repeat (65540) step();
        pi_exp_valid = 2'b00; step();
        pi_act_valid = 2'b00;
        chk(SEL_MATCH0, 64'hFFFF, "sat_match0"); chk(SEL_MIS0, 64'd0, "sat_mis0");
        chk(SEL_PASS, 64'd1, "sat_pass");
        end_test();

        // Reset in the middle of a check aborts the test.
        start_test(8'hFF);
        push_exp(0, 8'h12); drive_act(0, 8'h34);
        pi_rst = 1'b1;
        chk(SEL_ZERO, 64'd0, "midreset_outputs"); snap_now();
        pi_rst = 1'b0;
        pi_end_of_test = 1'b1; pi_act_valid = 2'b11; step();
        pi_end_of_test = 1'b0; pi_act_valid = 2'b00;
        chk(SEL_ZERO, 64'd0, "idle_ignores_inputs"); snap_now();

        // Start and end_of_test together in IDLE: start only.
        pi_start = 1'b1; pi_end_of_test = 1'b1; step();
        pi_start = 1'b0; pi_end_of_test = 1'b0; step();
        chk(SEL_READY, 64'h3, "start_wins_ready"); chk(SEL_BUSY, 64'd1, "start_wins_busy");
        snap_now();

        if (sbq.size() > 0) begin
            $display("FAIL unchecked_expectations: %0d left, required 0", sbq.size());
            total = total + sbq.size();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
